// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge: turns SPI chip-select frames into single (or, with SPI_REG_BRIDGE_BURST_EN, incrementing burst) register bus reads/writes.
// Latency: rx strobe -> o_bus_req 1 cycle; i_bus_ack -> o_tx_valid/o_bus_req drop 1 cycle (zero-wait read: 3 cycles strobe to load).
// Backpressure: none toward the slave; words arriving while an access is outstanding are dropped and flag sticky o_overrun.
module spi_reg_bridge #(
    parameter int K_DWIDTH = 16,
    parameter int K_AWIDTH = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [K_DWIDTH-1:0] i_rx_data,
    input  logic                i_rx_event,
    input  logic                i_selected,
    output logic [K_DWIDTH-1:0] o_tx_data,
    output logic                o_tx_valid,
    output logic                o_bus_req,
    output logic                o_bus_we,
    output logic [K_AWIDTH-1:0] o_bus_addr,
    output logic [K_DWIDTH-1:0] o_bus_wdata,
    input  logic                i_bus_ack,
    input  logic [K_DWIDTH-1:0] i_bus_rdata,
    output logic                o_overrun,
    output logic                o_busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CMD   = 3'd1,
        S_WDATA = 3'd2,
        S_WBUS  = 3'd3,
        S_RBUS  = 3'd4,
        S_RDATA = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t                state, state_nxt;
    logic [K_AWIDTH-1:0]   addr_nxt;
    logic [K_DWIDTH-1:0]   tx_data_nxt, wdata_nxt;
    logic                  tx_valid_nxt, req_nxt, we_nxt, overrun_nxt, busy_nxt;

`ifdef SPI_REG_BRIDGE_BURST_EN
    logic [K_AWIDTH-1:0]   addr_inc;
    assign addr_inc = o_bus_addr + K_AWIDTH'(1);
`endif

    always_comb begin
        state_nxt    = state;
        addr_nxt     = o_bus_addr;
        req_nxt      = o_bus_req;
        we_nxt       = o_bus_we;
        wdata_nxt    = o_bus_wdata;
        tx_data_nxt  = o_tx_data;
        tx_valid_nxt = 1'b0;
        overrun_nxt  = o_overrun;
        case (state)
            S_IDLE: begin
                if (i_selected) begin
                    state_nxt   = S_CMD;
                    overrun_nxt = 1'b0;
                end
            end
            S_CMD: begin
                if (!i_selected) begin
                    state_nxt = S_IDLE;
                end else if (i_rx_event) begin
                    addr_nxt = i_rx_data[K_AWIDTH-1:0];
                    if (i_rx_data[K_DWIDTH-1]) begin
                        state_nxt = S_WDATA;
                    end else begin
                        state_nxt = S_RBUS;
                        req_nxt   = 1'b1;
                        we_nxt    = 1'b0;
                    end
                end
            end
            S_WDATA: begin
                if (!i_selected) begin
                    state_nxt = S_IDLE;
                end else if (i_rx_event) begin
                    state_nxt = S_WBUS;
                    wdata_nxt = i_rx_data;
                    we_nxt    = 1'b1;
                    req_nxt   = 1'b1;
                end
            end
            // A deselect here must not abandon the request: wait for ack, then go idle.
            S_WBUS: begin
                if (i_rx_event) overrun_nxt = 1'b1;
                if (i_bus_ack && o_bus_req) begin
                    req_nxt = 1'b0;
                    if (!i_selected) begin
                        state_nxt = S_IDLE;
                    end else begin
`ifdef SPI_REG_BRIDGE_BURST_EN
                        state_nxt = S_WDATA;
                        addr_nxt  = addr_inc;
`else
                        state_nxt = S_DONE;
`endif
                    end
                end
            end
            S_RBUS: begin
                if (i_rx_event) overrun_nxt = 1'b1;
                if (i_bus_ack && o_bus_req) begin
                    req_nxt = 1'b0;
                    if (!i_selected) begin
                        state_nxt = S_IDLE;
                    end else begin
                        state_nxt    = S_RDATA;
                        tx_data_nxt  = i_bus_rdata;
                        tx_valid_nxt = 1'b1;
                    end
                end
            end
            S_RDATA: begin
                if (!i_selected) begin
                    state_nxt = S_IDLE;
                end else if (i_rx_event) begin
`ifdef SPI_REG_BRIDGE_BURST_EN
                    state_nxt = S_RBUS;
                    addr_nxt  = addr_inc;
                    req_nxt   = 1'b1;
                    we_nxt    = 1'b0;
`else
                    state_nxt = S_DONE;
`endif
                end
            end
            S_DONE: begin
                if (!i_selected) state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
                req_nxt   = 1'b0;
            end
        endcase
        busy_nxt = (state_nxt != S_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= S_IDLE;
            o_bus_addr  <= '0;
            o_bus_req   <= 1'b0;
            o_bus_we    <= 1'b0;
            o_bus_wdata <= '0;
            o_tx_data   <= '0;
            o_tx_valid  <= 1'b0;
            o_overrun   <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            state       <= state_nxt;
            o_bus_addr  <= addr_nxt;
            o_bus_req   <= req_nxt;
            o_bus_we    <= we_nxt;
            o_bus_wdata <= wdata_nxt;
            o_tx_data   <= tx_data_nxt;
            o_tx_valid  <= tx_valid_nxt;
            o_overrun   <= overrun_nxt;
            o_busy      <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Self-checking bench for spi_reg_bridge: frame-level reference model, randomized frames, and directed corner cases.
module tb_spi_reg_bridge;

`ifdef SPI_REG_BRIDGE_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [15:0] i_rx_data;
    logic        i_rx_event;
    logic        i_selected;
    logic [15:0] o_tx_data;
    logic        o_tx_valid;
    logic        o_bus_req;
    logic        o_bus_we;
    logic [7:0]  o_bus_addr;
    logic [15:0] o_bus_wdata;
    logic        i_bus_ack;
    logic [15:0] i_bus_rdata;
    logic        o_overrun;
    logic        o_busy;

    spi_reg_bridge #(.K_DWIDTH(16), .K_AWIDTH(8)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_rx_data(i_rx_data), .i_rx_event(i_rx_event),
        .i_selected(i_selected), .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid),
        .o_bus_req(o_bus_req), .o_bus_we(o_bus_we), .o_bus_addr(o_bus_addr),
        .o_bus_wdata(o_bus_wdata), .i_bus_ack(i_bus_ack), .i_bus_rdata(i_bus_rdata),
        .o_overrun(o_overrun), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    logic [15:0] mem [256];
    int          ack_delay = 0;
    bit          resp_en = 1'b1;
    int          wait_cnt = 0;

    logic [7:0]  acc_addr[$];
    bit          acc_we[$];
    logic [15:0] acc_wdata[$];
    logic [15:0] tx_q[$];
    int          tx_cq[$];
    int          req_rise_cyc = 0;
    int          unstable = 0;
    int          tx_desel = 0;
    logic [15:0] fw [8];
    int          strobe_cyc [8];

    // Bus responder: acks 1+ack_delay cycles after it first sees the request.
    initial begin
        i_bus_ack = 1'b0;
        i_bus_rdata = '0;
        forever begin
            @(posedge i_clk); #1;
            i_bus_ack = 1'b0;
            if (o_bus_req && resp_en) begin
                if (wait_cnt > ack_delay) begin
                    i_bus_ack   = 1'b1;
                    i_bus_rdata = mem[o_bus_addr];
                    acc_addr.push_back(o_bus_addr);
                    acc_we.push_back(o_bus_we);
                    acc_wdata.push_back(o_bus_wdata);
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else if (!o_bus_req) begin
                wait_cnt = 0;
            end
        end
    end

    // Output monitor: tx loads, request rise time, request-phase stability.
    initial begin
        logic        prev_req;
        logic [24:0] prev_bus;
        prev_req = 1'b0;
        prev_bus = '0;
        forever begin
            @(negedge i_clk);
            if (o_tx_valid) begin
                tx_q.push_back(o_tx_data);
                tx_cq.push_back(cyc);
                if (!i_selected) tx_desel++;
            end
            if (o_bus_req && !prev_req) req_rise_cyc = cyc;
            if (o_bus_req && prev_req && ({o_bus_addr, o_bus_we, o_bus_wdata} !== prev_bus)) unstable++;
            prev_req = o_bus_req;
            prev_bus = {o_bus_addr, o_bus_we, o_bus_wdata};
        end
    end

    task automatic tick;
        @(posedge i_clk); #1;
    endtask

    task automatic pulse_word(input logic [15:0] w);
        i_rx_data  = w;
        i_rx_event = 1'b1;
        tick();
        i_rx_event = 1'b0;
    endtask

    task automatic clear_logs;
        acc_addr.delete(); acc_we.delete(); acc_wdata.delete();
        tx_q.delete(); tx_cq.delete();
    endtask

    task automatic run_frame(input int n);
        clear_logs();
        i_selected = 1'b1;
        tick(); tick();
        for (int i = 0; i < n; i++) begin
            strobe_cyc[i] = cyc;
            pulse_word(fw[i]);
            repeat (ack_delay + 6) tick();
        end
        i_selected = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset;
        i_rst = 1'b1;
        repeat (3) tick();
        n_chk++;
        if ({o_tx_data, o_tx_valid, o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata, o_overrun, o_busy} !== 52'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got tx=%h v=%b req=%b we=%b a=%h wd=%h ovr=%b busy=%b, want all 0",
                     o_tx_data, o_tx_valid, o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata, o_overrun, o_busy);
        end
        i_rst = 1'b0;
        tick();
        n_chk++;
        if ({o_busy, o_bus_req} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b req=%b, want 0 0", o_busy, o_bus_req);
        end
    endtask

    task automatic test_single_write;
        ack_delay = 1;
        fw[0] = 16'h8012; fw[1] = 16'hBEEF;
        run_frame(2);
        n_chk++;
        if (acc_addr.size() !== 1) begin
            n_fail++;
            $display("FAIL write_count: got %0d accesses, want 1", acc_addr.size());
        end else begin
            n_chk++;
            if ({acc_addr[0], acc_we[0], acc_wdata[0]} !== {8'h12, 1'b1, 16'hBEEF}) begin
                n_fail++;
                $display("FAIL write_access: got a=%h we=%b wd=%h, want a=12 we=1 wd=beef", acc_addr[0], acc_we[0], acc_wdata[0]);
            end
        end
        n_chk++;
        if (tx_q.size() !== 0) begin
            n_fail++;
            $display("FAIL write_no_tx: got %0d tx loads, want 0", tx_q.size());
        end
        n_chk++;
        if (req_rise_cyc - strobe_cyc[1] !== 1) begin
            n_fail++;
            $display("FAIL write_req_latency: got %0d cycles, want 1", req_rise_cyc - strobe_cyc[1]);
        end
    endtask

    task automatic test_single_read;
        int nexp;
        ack_delay = 2;
        mem[8'h34] = 16'h1234;
        fw[0] = 16'h0034; fw[1] = 16'($urandom);
        run_frame(2);
        nexp = BURST ? 2 : 1;
        n_chk++;
        if (acc_addr.size() !== nexp || tx_q.size() !== nexp) begin
            n_fail++;
            $display("FAIL read_count: got %0d accesses %0d loads, want %0d", acc_addr.size(), tx_q.size(), nexp);
        end else begin
            n_chk++;
            if ({acc_addr[0], acc_we[0], tx_q[0]} !== {8'h34, 1'b0, 16'h1234}) begin
                n_fail++;
                $display("FAIL read_data: got a=%h we=%b tx=%h, want a=34 we=0 tx=1234", acc_addr[0], acc_we[0], tx_q[0]);
            end
            n_chk++;
            if (tx_cq[0] - strobe_cyc[0] !== 3 + ack_delay) begin
                n_fail++;
                $display("FAIL read_tx_latency: got %0d cycles, want %0d", tx_cq[0] - strobe_cyc[0], 3 + ack_delay);
            end
        end
    endtask

    task automatic test_read_latency;
        logic [7:0] a;
        ack_delay = 0;
        a = 8'($urandom);
        fw[0] = {1'b0, 7'($urandom), a};
        run_frame(1);
        n_chk++;
        if (req_rise_cyc - strobe_cyc[0] !== 1) begin
            n_fail++;
            $display("FAIL read_req_latency: got %0d cycles, want 1", req_rise_cyc - strobe_cyc[0]);
        end
        n_chk++;
        if (tx_q.size() !== 1 || tx_cq[0] - strobe_cyc[0] !== 3 || tx_q[0] !== mem[a]) begin
            n_fail++;
            $display("FAIL zero_wait_read: got %0d loads lat=%0d data=%h, want 1 lat=3 data=%h",
                     tx_q.size(), tx_cq.size() > 0 ? tx_cq[0] - strobe_cyc[0] : -1, tx_q.size() > 0 ? tx_q[0] : 16'h0, mem[a]);
        end
    endtask

    task automatic test_burst_read;
        logic [7:0] exp_a [4];
        int nexp;
        exp_a[0] = 8'hFE; exp_a[1] = 8'hFF; exp_a[2] = 8'h00; exp_a[3] = 8'h01;
        nexp = BURST ? 4 : 1;
        ack_delay = 1;
        fw[0] = 16'h00FE;
        for (int i = 1; i < 4; i++) fw[i] = 16'($urandom);
        run_frame(4);
        n_chk++;
        if (acc_addr.size() !== nexp || tx_q.size() !== nexp) begin
            n_fail++;
            $display("FAIL burst_count: got %0d accesses %0d loads, want %0d", acc_addr.size(), tx_q.size(), nexp);
        end
        for (int i = 0; i < nexp && i < acc_addr.size() && i < tx_q.size(); i++) begin
            n_chk++;
            if ({acc_addr[i], acc_we[i], tx_q[i]} !== {exp_a[i], 1'b0, mem[exp_a[i]]}) begin
                n_fail++;
                $display("FAIL burst_access[%0d]: got a=%h we=%b tx=%h, want a=%h we=0 tx=%h",
                         i, acc_addr[i], acc_we[i], tx_q[i], exp_a[i], mem[exp_a[i]]);
            end
        end
    endtask

    // Reference model: a frame's accesses follow from its command word and word count alone.
    task automatic test_random_frames;
        for (int f = 0; f < 14; f++) begin
            logic [7:0]  ea[$];
            logic [15:0] ed[$];
            logic [7:0]  a;
            bit          we;
            int          n, nacc;
            we = 1'($urandom);
            n  = we ? $urandom_range(2, 5) : $urandom_range(1, 5);
            ack_delay = $urandom_range(0, 3);
            fw[0] = {we, 7'($urandom), 8'($urandom)};
            for (int i = 1; i < n; i++) fw[i] = 16'($urandom);
            run_frame(n);
            if (we) nacc = BURST ? n - 1 : 1;
            else    nacc = BURST ? n : 1;
            for (int k = 0; k < nacc; k++) begin
                a = fw[0][7:0] + 8'(k);
                ea.push_back(a);
                ed.push_back(we ? fw[k + 1] : mem[a]);
            end
            n_chk++;
            if (acc_addr.size() !== nacc || tx_q.size() !== (we ? 0 : nacc)) begin
                n_fail++;
                $display("FAIL rand_count[%0d]: got %0d accesses %0d loads, want %0d %0d",
                         f, acc_addr.size(), tx_q.size(), nacc, we ? 0 : nacc);
            end else begin
                for (int k = 0; k < nacc; k++) begin
                    n_chk++;
                    if (acc_addr[k] !== ea[k] || acc_we[k] !== we || (we ? acc_wdata[k] : tx_q[k]) !== ed[k]) begin
                        n_fail++;
                        $display("FAIL rand_access[%0d.%0d]: got a=%h we=%b d=%h, want a=%h we=%b d=%h", f, k,
                                 acc_addr[k], acc_we[k], we ? acc_wdata[k] : tx_q[k], ea[k], we, ed[k]);
                    end
                end
            end
            n_chk++;
            if ({o_overrun, o_busy, o_bus_req} !== 3'b000) begin
                n_fail++;
                $display("FAIL rand_end_state[%0d]: ovr=%b busy=%b req=%b, want 0 0 0", f, o_overrun, o_busy, o_bus_req);
            end
        end
    endtask

    task automatic test_overrun;
        ack_delay = 0;
        resp_en = 1'b0;
        clear_logs();
        i_selected = 1'b1;
        tick(); tick();
        pulse_word(16'h0040);
        tick();
        pulse_word(16'hAAAA);
        n_chk++;
        if ({o_overrun, o_bus_req} !== 2'b11) begin
            n_fail++;
            $display("FAIL overrun_set: ovr=%b req=%b, want 1 1", o_overrun, o_bus_req);
        end
        resp_en = 1'b1;
        repeat (4) tick();
        n_chk++;
        if (tx_q.size() !== 1 || tx_q[0] !== mem[8'h40]) begin
            n_fail++;
            $display("FAIL overrun_read_data: got %0d loads first=%h, want 1 %h", tx_q.size(), tx_q.size() > 0 ? tx_q[0] : 16'h0, mem[8'h40]);
        end
        pulse_word(16'h5555);
        repeat (6) tick();
        i_selected = 1'b0;
        repeat (3) tick();
        n_chk++;
        if ({o_overrun, o_busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL overrun_sticky: ovr=%b busy=%b, want 1 0", o_overrun, o_busy);
        end
        i_selected = 1'b1;
        tick(); tick();
        n_chk++;
        if ({o_overrun, o_busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL overrun_clear: ovr=%b busy=%b, want 0 1", o_overrun, o_busy);
        end
        i_selected = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_deselect_rbus;
        ack_delay = 0;
        resp_en = 1'b0;
        clear_logs();
        i_selected = 1'b1;
        tick(); tick();
        pulse_word(16'h0050);
        tick();
        i_selected = 1'b0;
        repeat (4) tick();
        n_chk++;
        if ({o_bus_req, o_busy} !== 2'b11) begin
            n_fail++;
            $display("FAIL desel_hold_req: req=%b busy=%b, want 1 1", o_bus_req, o_busy);
        end
        resp_en = 1'b1;
        repeat (4) tick();
        n_chk++;
        if ({o_bus_req, o_busy} !== 2'b00 || tx_q.size() !== 0 || acc_addr.size() !== 1) begin
            n_fail++;
            $display("FAIL desel_complete: req=%b busy=%b loads=%0d accesses=%0d, want 0 0 0 1",
                     o_bus_req, o_busy, tx_q.size(), acc_addr.size());
        end
    endtask

    task automatic test_reset_wbus;
        resp_en = 1'b0;
        i_selected = 1'b1;
        tick(); tick();
        pulse_word(16'h8077);
        pulse_word(16'h5A5A);
        n_chk++;
        if ({o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata} !== {1'b1, 1'b1, 8'h77, 16'h5A5A}) begin
            n_fail++;
            $display("FAIL wbus_setup: req=%b we=%b a=%h wd=%h, want 1 1 77 5a5a", o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata);
        end
        i_rst = 1'b1;
        tick();
        n_chk++;
        if ({o_tx_data, o_tx_valid, o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata, o_overrun, o_busy} !== 52'd0) begin
            n_fail++;
            $display("FAIL reset_in_wbus: req=%b we=%b a=%h wd=%h busy=%b, want all 0", o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata, o_busy);
        end
        i_rst = 1'b0;
        i_selected = 1'b0;
        resp_en = 1'b1;
        repeat (3) tick();
        n_chk++;
        if ({o_busy, o_bus_req} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_recover: busy=%b req=%b, want 0 0", o_busy, o_bus_req);
        end
    endtask

    initial begin
        i_rst = 1'b1;
        i_rx_data = '0;
        i_rx_event = 1'b0;
        i_selected = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        test_reset();
        test_single_write();
        test_single_read();
        test_read_latency();
        test_burst_read();
        test_random_frames();
        test_overrun();
        test_deselect_rbus();
        test_reset_wbus();
        n_chk++;
        if (unstable !== 0 || tx_desel !== 0) begin
            n_fail++;
            $display("FAIL bus_protocol: %0d unstable request cycles, %0d deselected loads, want 0 0", unstable, tx_desel);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
